// File: rtl/axi_lite_regbank_responder_if.sv
// AXI4-Lite bundle between the system master and the register-bank responder.
// The master modport drives requests and response-readies; the slave modport answers them.
interface axi_lite_regbank_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_regbank_responder.sv
// AXI4-Lite responder with an integrated register bank.
// Write and read channels run as two independent two-state FSMs; every bus output is
// a register so the master never sees a combinational path through this block.
module axi_lite_regbank_responder #(
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  DATA_WIDTH = 32,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input logic                          aclk,
   input logic                          aresetn,
   axi_lite_regbank_responder_if.slave  bus
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic { W_IDLE, W_RESP } wState_t;
   typedef enum logic { R_IDLE, R_DATA } rState_t;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   wState_t               r_wState;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_awHeld;
   logic                  r_wHeld;
   logic [ADDR_WIDTH-1:0] r_awAddr;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRB_W-1:0]     r_wStrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   rState_t               r_rState;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   logic                  w_awFire;
   logic                  w_wFire;
   logic                  w_haveAw;
   logic                  w_haveW;
   logic [ADDR_WIDTH-1:0] w_wAddr;
   logic [DATA_WIDTH-1:0] w_wData;
   logic [STRB_W-1:0]     w_wStrb;
   logic [IDX_W-1:0]      w_wIdx;
   logic                  w_wInRange;
   logic                  w_wReject;
   logic                  w_arFire;
   logic [IDX_W-1:0]      w_rIdx;
   logic                  w_rInRange;

   // A beat arriving this cycle takes priority over the holding register, so AW and W
   // landing on the same edge (or the second of the two landing) commit immediately.
   assign w_awFire   = bus.awvalid & r_awready;
   assign w_wFire    = bus.wvalid & r_wready;
   assign w_haveAw   = r_awHeld | w_awFire;
   assign w_haveW    = r_wHeld | w_wFire;
   assign w_wAddr    = w_awFire ? bus.awaddr : r_awAddr;
   assign w_wData    = w_wFire ? bus.wdata : r_wData;
   assign w_wStrb    = w_wFire ? bus.wstrb : r_wStrb;
   assign w_wIdx     = w_wAddr[LSB +: IDX_W];
   assign w_wInRange = ((w_wAddr >> (LSB + IDX_W)) == '0);
   assign w_wReject  = !w_wInRange || RO_MASK[w_wIdx];

   assign w_arFire   = bus.arvalid & r_arready;
   assign w_rIdx     = bus.araddr[LSB +: IDX_W];
   assign w_rInRange = ((bus.araddr >> (LSB + IDX_W)) == '0);

   assign bus.awready = r_awready;
   assign bus.wready  = r_wready;
   assign bus.bvalid  = r_bvalid;
   assign bus.bresp   = r_bresp;
   assign bus.arready = r_arready;
   assign bus.rvalid  = r_rvalid;
   assign bus.rdata   = r_rdata;
   assign bus.rresp   = r_rresp;

   // Write channel FSM: collects AW and W in either order, commits to the bank, holds B.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wState  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_awHeld  <= 1'b0;
         r_wHeld   <= 1'b0;
         r_awAddr  <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_wState)
            W_IDLE: begin
               if (w_awFire) begin
                  r_awAddr <= bus.awaddr;
               end
               if (w_wFire) begin
                  r_wData <= bus.wdata;
                  r_wStrb <= bus.wstrb;
               end
               if (w_haveAw && w_haveW) begin
                  if (w_wReject) begin
                     r_bresp <= RESP_SLVERR;
                  end else begin
                     r_bresp <= RESP_OKAY;
                     for (int k = 0; k < STRB_W; k++) begin
                        if (w_wStrb[k]) begin
                           r_regs[w_wIdx][8*k +: 8] <= w_wData[8*k +: 8];
                        end
                     end
                  end
                  r_awHeld  <= 1'b0;
                  r_wHeld   <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_wState  <= W_RESP;
               end else begin
                  r_awHeld  <= w_haveAw;
                  r_wHeld   <= w_haveW;
                  r_awready <= !w_haveAw;
                  r_wready  <= !w_haveW;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wState  <= W_IDLE;
               end
            end
            default: begin
               r_wState <= W_IDLE;
            end
         endcase
      end
   end

   // Read channel FSM: samples the bank as it stood before this edge, then holds R.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rState  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_rState)
            R_IDLE: begin
               if (w_arFire) begin
                  r_rdata   <= w_rInRange ? r_regs[w_rIdx] : '0;
                  r_rresp   <= w_rInRange ? RESP_OKAY : RESP_SLVERR;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rState  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rState  <= R_IDLE;
               end
            end
            default: begin
               r_rState <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_regbank_responder.sv
// Directed bench for axi_lite_regbank_responder with register 0 write-protected.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_lite_regbank_responder;

   logic aclk;
   logic aresetn;
   int   vectors;
   int   miscompares;

   axi_lite_regbank_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_regbank_responder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (16),
      .RO_MASK    (16'h0001)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   // Free-running 100 MHz clock.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Same-cycle AW+W write; returns B response and cycles from request to bvalid.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                output logic [1:0] resp, output int lat);
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.bvalid && lat < 20);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!bus.bvalid) lat = 99;
      resp = bus.bresp;
   endtask

   task automatic acceptB();
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic applyRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.rvalid && lat < 20);
      bus.arvalid = 1'b0;
      if (!bus.rvalid) lat = 99;
      data = bus.rdata;
      resp = bus.rresp;
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat;

      vectors     = 0;
      miscompares = 0;
      aresetn     = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;

      tick();
      tick();
      tick();
      checkOutput("reset_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'h0);
      checkOutput("reset_valids", {62'd0, bus.bvalid, bus.rvalid}, 64'h0);
      checkOutput("reset_resp_data", {28'd0, bus.bresp, bus.rresp, bus.rdata}, 64'h0);
      aresetn = 1'b1;
      tick();
      checkOutput("release_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'h7);

      // AW+W same cycle to 0x08
      applyStimulus(32'h08, 32'hDEADBEEF, 4'hF, resp, lat);
      checkOutput("wr08_latency", lat, 1);
      checkOutput("wr08_bresp", resp, 2'b00);
      checkOutput("wr08_readies_in_resp", {62'd0, bus.awready, bus.wready}, 64'h0);
      acceptB();
      checkOutput("wr08_bvalid_cleared", bus.bvalid, 1'b0);
      checkOutput("wr08_readies_back", {62'd0, bus.awready, bus.wready}, 64'h3);
      applyRead(32'h08, data, resp, lat);
      checkOutput("rd08_data", data, 32'hDEADBEEF);
      checkOutput("rd08_rresp", resp, 2'b00);
      checkOutput("rd08_latency", lat, 1);

      // W first, AW three cycles later, partial strobes
      bus.wdata  = 32'h11223344;
      bus.wstrb  = 4'b0101;
      bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      checkOutput("wfirst_held", {61'd0, bus.wready, bus.awready, bus.bvalid}, 64'h2);
      tick();
      tick();
      checkOutput("wfirst_wait", {61'd0, bus.wready, bus.awready, bus.bvalid}, 64'h2);
      bus.awaddr  = 32'h08;
      bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      checkOutput("wfirst_bvalid", bus.bvalid, 1'b1);
      checkOutput("wfirst_bresp", bus.bresp, 2'b00);
      acceptB();
      applyRead(32'h08, data, resp, lat);
      checkOutput("wfirst_merge", data, 32'hDE22BE44);

      // Out-of-range and read-only writes
      applyStimulus(32'h40, 32'hFFFFFFFF, 4'hF, resp, lat);
      checkOutput("wr40_slverr", resp, 2'b10);
      acceptB();
      applyStimulus(32'h00, 32'h12345678, 4'hF, resp, lat);
      checkOutput("wr_ro_slverr", resp, 2'b10);
      acceptB();
      applyRead(32'h00, data, resp, lat);
      checkOutput("rd00_unchanged", {30'd0, resp, data}, 64'h0);
      applyRead(32'h40, data, resp, lat);
      checkOutput("rd40_slverr", {30'd0, resp, data}, {30'd0, 2'b10, 32'h0});
      applyRead(32'h1000_0008, data, resp, lat);
      checkOutput("rd_highbit_slverr", {30'd0, resp, data}, {30'd0, 2'b10, 32'h0});
      applyRead(32'h0B, data, resp, lat);
      checkOutput("rd_lowbits_ignored", data, 32'hDE22BE44);

      // Simultaneous write and read of the same register
      applyStimulus(32'h04, 32'h1, 4'hF, resp, lat);
      acceptB();
      bus.awaddr  = 32'h04;
      bus.wdata   = 32'h5;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.araddr  = 32'h04;
      bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.arvalid = 1'b0;
      checkOutput("rw_same_valids", {62'd0, bus.bvalid, bus.rvalid}, 64'h3);
      checkOutput("rw_same_old_data", bus.rdata, 32'h1);
      bus.bready = 1'b1;
      bus.rready = 1'b1;
      tick();
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      checkOutput("rw_same_done", {62'd0, bus.bvalid, bus.rvalid}, 64'h0);
      applyRead(32'h04, data, resp, lat);
      checkOutput("rw_same_new_data", data, 32'h5);

      // Zero strobes: OKAY with no change
      applyStimulus(32'h04, 32'hFFFFFFFF, 4'h0, resp, lat);
      checkOutput("strb0_okay", resp, 2'b00);
      acceptB();
      applyRead(32'h04, data, resp, lat);
      checkOutput("strb0_unchanged", data, 32'h5);

      // Write-response backpressure while reads continue
      applyStimulus(32'h0C, 32'hA5A5A5A5, 4'hF, resp, lat);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp_hold_a", {59'd0, bus.bvalid, bus.bresp, bus.awready, bus.wready}, 64'h10);
         tick();
      end
      applyRead(32'h08, data, resp, lat);
      checkOutput("bp_read_completes", data, 32'hDE22BE44);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp_hold_b", {59'd0, bus.bvalid, bus.bresp, bus.awready, bus.wready}, 64'h10);
         tick();
      end
      acceptB();
      applyRead(32'h0C, data, resp, lat);
      checkOutput("bp_written", data, 32'hA5A5A5A5);

      // Reset with both channels mid-response
      applyStimulus(32'h10, 32'h77, 4'hF, resp, lat);
      bus.araddr  = 32'h08;
      bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      checkOutput("pre_reset_busy", {62'd0, bus.bvalid, bus.rvalid}, 64'h3);
      aresetn = 1'b0;
      tick();
      checkOutput("midreset_valids", {62'd0, bus.bvalid, bus.rvalid}, 64'h0);
      checkOutput("midreset_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'h0);
      checkOutput("midreset_rdata", bus.rdata, 32'h0);
      aresetn = 1'b1;
      tick();
      checkOutput("postreset_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'h7);
      checkOutput("postreset_no_resp", {62'd0, bus.bvalid, bus.rvalid}, 64'h0);
      applyRead(32'h08, data, resp, lat);
      checkOutput("postreset_reg08", data, 32'h0);
      applyRead(32'h10, data, resp, lat);
      checkOutput("postreset_reg10", data, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
